// File: rtl/change_dispenser.sv
// Greedy three-denomination change dispenser, one coin per ejector handshake.
// Define COIN_INV_EN to add per-denomination inventory, refill port and short flag.
module change_dispenser #(
  parameter int unsigned AMT_W    = 8,
  parameter int unsigned COIN_HI  = 10,
  parameter int unsigned COIN_MID = 5,
  parameter int unsigned COIN_LO  = 1
`ifdef COIN_INV_EN
  ,
  parameter int unsigned INV_W    = 4,
  parameter int unsigned INV_INIT = 8
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [AMT_W-1:0] total_amount,
  input  logic [AMT_W-1:0] product_price,
  output logic             busy,
  output logic [AMT_W-1:0] change_amount,
  output logic [AMT_W-1:0] remaining,
  output logic             coin_valid,
  output logic [1:0]       coin_sel,
  input  logic             coin_ready,
`ifdef COIN_INV_EN
  input  logic             refill_valid,
  input  logic [1:0]       refill_sel,
  input  logic [INV_W-1:0] refill_cnt,
  output logic             short,
`endif
  output logic             done,
  output logic             err
);

  localparam logic [AMT_W-1:0] V_HI  = AMT_W'(COIN_HI);
  localparam logic [AMT_W-1:0] V_MID = AMT_W'(COIN_MID);
  localparam logic [AMT_W-1:0] V_LO  = AMT_W'(COIN_LO);

  typedef enum logic [2:0] {S_IDLE, S_CALC, S_DISP, S_DONE, S_ERR} state_t;

  state_t           r_state, w_state_nxt;
  logic [AMT_W-1:0] r_total, r_price, r_change, r_rem;
  logic [AMT_W-1:0] w_total_nxt, w_price_nxt, w_change_nxt, w_rem_nxt;
  logic             r_busy, r_valid, r_done, r_err;
  logic [1:0]       r_sel, w_sel_nxt;
  logic             w_valid_nxt, w_fire;
  logic [2:0]       w_avail, w_avail_nxt, w_use_cur, w_use_nxt;

  // Bit d set when denomination d is in stock and fits in rem.
  function automatic logic [2:0] f_usable(input logic [AMT_W-1:0] rem, input logic [2:0] avail);
    f_usable = {avail[2] && (rem >= V_HI), avail[1] && (rem >= V_MID), avail[0] && (rem >= V_LO)};
  endfunction

  function automatic logic [1:0] f_pick(input logic [2:0] use_mask);
    if (use_mask[2])      f_pick = 2'd2;
    else if (use_mask[1]) f_pick = 2'd1;
    else                  f_pick = 2'd0;
  endfunction

  function automatic logic [AMT_W-1:0] f_value(input logic [1:0] sel);
    case (sel)
      2'd2:    f_value = V_HI;
      2'd1:    f_value = V_MID;
      default: f_value = V_LO;
    endcase
  endfunction

  assign w_fire    = r_valid & coin_ready;
  assign w_use_cur = f_usable(r_rem, w_avail);
  assign w_use_nxt = f_usable(w_rem_nxt, w_avail_nxt);

`ifdef COIN_INV_EN
  localparam int unsigned SUM_W   = INV_W + 1;
  localparam int unsigned INV_MAX = (1 << INV_W) - 1;

  logic [INV_W-1:0] r_inv [3];
  logic [INV_W-1:0] w_inv_nxt [3];
  logic [SUM_W-1:0] w_sum [3];
  logic             r_short, w_short_nxt;

  // Refill and dispense may hit the same denomination in one cycle; result saturates.
  always_comb begin
    for (int d = 0; d < 3; d++) begin
      w_sum[d] = {1'b0, r_inv[d]};
      if (refill_valid && (refill_sel == 2'(d))) w_sum[d] = w_sum[d] + SUM_W'(refill_cnt);
      if (w_fire && (r_sel == 2'(d)))           w_sum[d] = w_sum[d] - SUM_W'(1);
      w_inv_nxt[d]   = (w_sum[d] > SUM_W'(INV_MAX)) ? INV_W'(INV_MAX) : w_sum[d][INV_W-1:0];
      w_avail_nxt[d] = (w_inv_nxt[d] != '0);
      w_avail[d]     = (r_inv[d] != '0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int d = 0; d < 3; d++) r_inv[d] <= INV_W'(INV_INIT);
      r_short <= 1'b0;
    end else begin
      for (int d = 0; d < 3; d++) r_inv[d] <= w_inv_nxt[d];
      r_short <= w_short_nxt;
    end
  end

  assign short = r_short;
`else
  assign w_avail     = 3'b111;
  assign w_avail_nxt = 3'b111;
`endif

  // Next-state and datapath.
  always_comb begin
    w_state_nxt  = r_state;
    w_total_nxt  = r_total;
    w_price_nxt  = r_price;
    w_change_nxt = r_change;
    w_rem_nxt    = r_rem;
`ifdef COIN_INV_EN
    w_short_nxt  = 1'b0;
`endif
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_total_nxt = total_amount;
          w_price_nxt = product_price;
          w_state_nxt = S_CALC;
        end
      end
      S_CALC: begin
        if (r_total < r_price) begin
          w_change_nxt = '0;
          w_rem_nxt    = '0;
          w_state_nxt  = S_ERR;
        end else begin
          w_change_nxt = r_total - r_price;
          w_rem_nxt    = r_total - r_price;
          w_state_nxt  = S_DISP;
        end
      end
      S_DISP: begin
        if (w_fire) w_rem_nxt = r_rem - f_value(r_sel);
        if (r_rem == '0) begin
          w_state_nxt = S_DONE;
        end else if (w_use_cur == 3'b000) begin
          // Out of usable coins: finish and leave the unpaid amount in remaining.
          w_state_nxt = S_DONE;
`ifdef COIN_INV_EN
          w_short_nxt = 1'b1;
`endif
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      S_ERR:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Coin request: frozen while the ejector stalls, otherwise greedy on the next remainder.
  always_comb begin
    w_valid_nxt = 1'b0;
    w_sel_nxt   = r_sel;
    if (r_valid && !coin_ready) begin
      w_valid_nxt = 1'b1;
    end else begin
      w_valid_nxt = (w_state_nxt == S_DISP) && (w_use_nxt != 3'b000);
      w_sel_nxt   = f_pick(w_use_nxt);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_total  <= '0;
      r_price  <= '0;
      r_change <= '0;
      r_rem    <= '0;
      r_busy   <= 1'b0;
      r_valid  <= 1'b0;
      r_sel    <= 2'd0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_total  <= w_total_nxt;
      r_price  <= w_price_nxt;
      r_change <= w_change_nxt;
      r_rem    <= w_rem_nxt;
      r_busy   <= (w_state_nxt != S_IDLE);
      r_valid  <= w_valid_nxt;
      r_sel    <= w_sel_nxt;
      r_done   <= (w_state_nxt == S_DONE);
      r_err    <= (w_state_nxt == S_ERR);
    end
  end

  assign busy          = r_busy;
  assign change_amount = r_change;
  assign remaining     = r_rem;
  assign coin_valid    = r_valid;
  assign coin_sel      = r_sel;
  assign done          = r_done;
  assign err           = r_err;

endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser with a greedy-change reference model and per-cycle monitor.
// Build with COIN_INV_EN defined to also exercise the inventory scenario.
`timescale 1ns/1ps
module tb_change_dispenser;

  logic       clk = 1'b0;
  logic       rst, start, coin_ready;
  logic [7:0] total_amount, product_price;
  logic       busy, coin_valid, done, err;
  logic [7:0] change_amount, remaining;
  logic [1:0] coin_sel;
`ifdef COIN_INV_EN
  logic       refill_valid;
  logic [1:0] refill_sel;
  logic [3:0] refill_cnt;
  logic       short;
`endif

`ifdef COIN_INV_EN
  change_dispenser #(.AMT_W(8), .INV_INIT(0)) dut (
    .clk(clk), .rst(rst), .start(start),
    .total_amount(total_amount), .product_price(product_price),
    .busy(busy), .change_amount(change_amount), .remaining(remaining),
    .coin_valid(coin_valid), .coin_sel(coin_sel), .coin_ready(coin_ready),
    .refill_valid(refill_valid), .refill_sel(refill_sel), .refill_cnt(refill_cnt), .short(short),
    .done(done), .err(err)
  );
`else
  change_dispenser #(.AMT_W(8)) dut (
    .clk(clk), .rst(rst), .start(start),
    .total_amount(total_amount), .product_price(product_price),
    .busy(busy), .change_amount(change_amount), .remaining(remaining),
    .coin_valid(coin_valid), .coin_sel(coin_sel), .coin_ready(coin_ready),
    .done(done), .err(err)
  );
`endif

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;
  int dval [3] = '{1, 5, 10};
  int exp_q [$];
  int m_inv [3];
  int m_rem, m_change;
  bit m_is_err;
  bit mon_en = 1'b0;
`ifdef COIN_INV_EN
  bit m_short;
`endif

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic reset_model();
    for (int d = 0; d < 3; d++) begin
`ifdef COIN_INV_EN
      m_inv[d] = 0;
`else
      m_inv[d] = 1000;
`endif
    end
  endtask

  // Expected coin list: repeatedly take the biggest stocked coin that fits.
  task automatic plan(input int tot, input int pr);
    int  r;
    bit  found;
    exp_q.delete();
    m_is_err = (tot < pr);
    m_change = m_is_err ? 0 : tot - pr;
    r = m_change;
    while (r > 0) begin
      found = 1'b0;
      for (int d = 2; d >= 0; d--) begin
        if (!found && dval[d] <= r && m_inv[d] > 0) begin
          exp_q.push_back(d);
          r -= dval[d];
          m_inv[d]--;
          found = 1'b1;
        end
      end
      if (!found) break;
    end
    m_rem = m_change;
`ifdef COIN_INV_EN
    m_short = (r != 0);
`endif
  endtask

  // Per-cycle compare against the model while a transaction is in flight.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("busy", busy, 1);
      if (coin_valid) begin
        chk("coin_pending", int'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          chk("coin_sel", coin_sel, exp_q[0]);
          chk("remaining", remaining, m_rem);
          if (coin_ready) begin
            m_rem -= dval[exp_q[0]];
            void'(exp_q.pop_front());
          end
        end
      end
      if (done || err) begin
        chk("end_kind", {done, err}, m_is_err ? 1 : 2);
        chk("coins_left", exp_q.size(), 0);
        chk("remaining_end", remaining, m_rem);
        chk("change_amount", change_amount, m_change);
`ifdef COIN_INV_EN
        chk("short", short, m_short);
`endif
      end
    end
  end

`ifdef COIN_INV_EN
  task automatic refill(input int sel, input int cnt);
    @(posedge clk); #1;
    refill_valid = 1'b1; refill_sel = 2'(sel); refill_cnt = 4'(cnt);
    @(posedge clk); #1;
    refill_valid = 1'b0;
    m_inv[sel] = (m_inv[sel] + cnt > 15) ? 15 : m_inv[sel] + cnt;
  endtask

  task automatic refill_all();
    for (int d = 0; d < 3; d++) refill(d, 15);
  endtask
`endif

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    reset_model();
  endtask

  // One transaction; k counts clock edges after the accepting edge.
  task automatic run_txn(input int tot, input int pr, input bit hold_start, input int stall_len,
                         input int abort_after, output int t_first, output int t_end, output int seq);
    int k, accepted, stall;
    bit fin;
    plan(tot, pr);
    t_first = -1; t_end = -1; seq = 0; accepted = 0; stall = stall_len; fin = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; total_amount = 8'(tot); product_price = 8'(pr); coin_ready = 1'b1;
    @(posedge clk); #1;
    if (!hold_start) start = 1'b0;
    mon_en = 1'b1;
    k = 1;
    while (!fin && k < 80) begin
      @(negedge clk);
      if (coin_valid && t_first < 0) t_first = k;
      if (coin_valid && coin_ready) begin
        accepted++;
        seq = seq * 4 + int'(coin_sel);
      end
      if (done || err) begin
        t_end = k;
        fin = 1'b1;
      end
      @(posedge clk); #1;
      k++;
      start = 1'b0;
      if (!fin && abort_after > 0 && accepted == abort_after) begin
        mon_en = 1'b0;
        rst = 1'b1;
        #1;
        chk("abort_coin_valid", coin_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_remaining", remaining, 0);
        chk("abort_change", change_amount, 0);
        chk("abort_done", done, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        reset_model();
        return;
      end
      coin_ready = !(coin_valid && accepted == 1 && stall > 0);
      if (!coin_ready) stall--;
    end
    mon_en = 1'b0;
    if (!fin) begin
      n_cmp++;
      n_fail++;
      $display("FAIL txn_timeout: got no done/err, expected one within 80 cycles");
    end
  endtask

  initial begin
    int t_first, t_end, seq;
    rst = 1'b1; start = 1'b0; coin_ready = 1'b1; total_amount = '0; product_price = '0;
`ifdef COIN_INV_EN
    refill_valid = 1'b0; refill_sel = '0; refill_cnt = '0;
`endif
    reset_model();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_coin_valid", coin_valid, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_change", change_amount, 0);
    chk("rst_remaining", remaining, 0);
    rst = 1'b0;
`ifdef COIN_INV_EN
    refill_all();
`endif

    // 37-14=23: HI,HI,LO,LO,LO back to back
    run_txn(37, 14, 1'b0, 0, 0, t_first, t_end, seq);
    chk("t1_first_coin", t_first, 2);
    chk("t1_seq", seq, 640);
    chk("t1_done", t_end, 8);
    chk("t1_change", change_amount, 23);

    // Same with a 3-cycle stall on the second coin
    run_txn(37, 14, 1'b0, 3, 0, t_first, t_end, seq);
    chk("t2_first_coin", t_first, 2);
    chk("t2_seq", seq, 640);
    chk("t2_done", t_end, 11);

    // Exact payment: no coins, done 3 cycles after accept
    run_txn(14, 14, 1'b0, 0, 0, t_first, t_end, seq);
    chk("t3_no_coin", t_first, -1);
    chk("t3_done", t_end, 3);

    // Underpayment with start held into CALC
    run_txn(5, 9, 1'b1, 0, 0, t_first, t_end, seq);
    chk("t4_no_coin", t_first, -1);
    chk("t4_err", t_end, 2);
    chk("t4_change", change_amount, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t4_idle_busy", busy, 0);
      chk("t4_err_pulse", err, 0);
      chk("t4_idle_valid", coin_valid, 0);
    end

    // Abort after the second coin, then 20-3=17: HI,MID,LO,LO
    run_txn(37, 14, 1'b0, 0, 2, t_first, t_end, seq);
`ifdef COIN_INV_EN
    refill_all();
`endif
    run_txn(20, 3, 1'b0, 0, 0, t_first, t_end, seq);
    chk("t5_first_coin", t_first, 2);
    chk("t5_seq", seq, 144);
    chk("t5_done", t_end, 7);
    chk("t5_change", change_amount, 17);

`ifdef COIN_INV_EN
    // One HI coin in stock: HI,MID,MID,LO,LO,LO
    do_reset();
    refill(2, 1);
    refill(1, 8);
    refill(0, 8);
    run_txn(37, 14, 1'b0, 0, 0, t_first, t_end, seq);
    chk("t6_seq", seq, 2368);
    chk("t6_done", t_end, 9);
    // Empty inventory: short with the whole change unpaid
    do_reset();
    run_txn(37, 14, 1'b0, 0, 0, t_first, t_end, seq);
    chk("t6_short_no_coin", t_first, -1);
    chk("t6_short_done", t_end, 3);
    chk("t6_short_rem", remaining, 23);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
